// File: rtl/uart_rx.sv
// UART receive engine: 2-flop synchronizer, oversampled start/data/parity/stop
// framing, and a valid/ready holding register with framing/parity/overrun status.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_clk,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_reg;
    logic                   rxd_meta_reg;
    logic                   rxs_reg;
    logic [TW-1:0]          tick_cnt_reg;
    logic [BW-1:0]          bit_cnt_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   shift_next;
    logic                   load_pend_reg;
    logic                   frame_pend_reg;
    logic                   parity_pend_reg;
    logic                   parity_next;

    logic [DATA_BITS-1:0]   rx_data_reg;
    logic                   rx_valid_reg;
    logic                   frame_err_reg;
    logic                   parity_err_reg;
    logic                   overrun_reg;

    // Both synchronizer stages idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_reg <= 1'b1;
            rxs_reg      <= 1'b1;
        end else begin
            rxd_meta_reg <= rxd;
            rxs_reg      <= rxd_meta_reg;
        end
    end

    // LSB-first: each new sample enters at the MSB and the frame shifts down.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            if (gi == DATA_BITS - 1) begin : g_top
                assign shift_next[gi] = rxs_reg;
            end else begin : g_mid
                assign shift_next[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        parity_next = 1'b0;
        if (PARITY == 1) begin
            parity_next = ~(^shift_reg ^ rxs_reg);
        end else if (PARITY == 2) begin
            parity_next = ^shift_reg ^ rxs_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            tick_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            load_pend_reg   <= 1'b0;
            frame_pend_reg  <= 1'b0;
            parity_pend_reg <= 1'b0;
        end else begin
            load_pend_reg <= 1'b0;
            if (rx_clk) begin
                case (state_reg)
                    S_IDLE: begin
                        if (!rxs_reg) begin
                            state_reg    <= S_START;
                            tick_cnt_reg <= '0;
                        end
                    end
                    S_START: begin
                        if (tick_cnt_reg == HALF_LAST) begin
                            tick_cnt_reg <= '0;
                            if (rxs_reg) begin
                                state_reg <= S_IDLE;
                            end else begin
                                state_reg   <= S_DATA;
                                bit_cnt_reg <= '0;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (tick_cnt_reg == FULL_LAST) begin
                            tick_cnt_reg <= '0;
                            shift_reg    <= shift_next;
                            if (bit_cnt_reg == LAST_BIT) begin
                                state_reg <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (tick_cnt_reg == FULL_LAST) begin
                            tick_cnt_reg    <= '0;
                            parity_pend_reg <= parity_next;
                            state_reg       <= S_STOP;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (tick_cnt_reg == FULL_LAST) begin
                            tick_cnt_reg   <= '0;
                            frame_pend_reg <= ~rxs_reg;
                            load_pend_reg  <= 1'b1;
                            state_reg      <= rxs_reg ? S_IDLE : S_BREAK;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    S_BREAK: begin
                        if (rxs_reg) begin
                            state_reg <= S_IDLE;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    // Holding register runs every clk; a load always beats a same-cycle consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (load_pend_reg) begin
                rx_data_reg    <= shift_reg;
                frame_err_reg  <= frame_pend_reg;
                parity_err_reg <= parity_pend_reg;
                rx_valid_reg   <= 1'b1;
                overrun_reg    <= rx_valid_reg & ~rx_ready;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive engine that pairs with the existing baud-rate tick generator and the transmit path. It samples serial line rxd using the rx_clk oversampling tick (OVERSAMPLE ticks per bit). It reassembles LSB-first frames of start, data, optional parity and stop bits. Each received byte is presented on a valid/ready holding register, with framing, parity and overrun status.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
OVERSAMPLE, 16, rx_clk ticks per bit period (even, >=4)
PARITY, 0, 0 = none, 1 = odd, 2 = even

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_clk  input  1  one-clk-wide enable pulse at OVERSAMPLE x baud rate
rxd  input  1  asynchronous serial input, idle high
rx_data  output  DATA_BITS  received byte, valid while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
frame_err  output  1  stop bit sampled 0; qualifies current rx_data
parity_err  output  1  parity mismatch; qualifies current rx_data
overrun  output  1  one-clk pulse: completed frame overwrote unconsumed data

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Synchronizer: rxd passes through 2 flops. Both flops reset to 1. All decisions use the synchronized value rxs.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, state=IDLE, tick counter=0, bit counter=0.
- rst mid-frame aborts the frame immediately; no partial data is delivered.
- State and counter updates occur only on clk edges where rx_clk=1, except the output handshake, which updates every clk.
- IDLE: on a tick with rxs=0, go to START and clear the tick counter.
- START: on tick count OVERSAMPLE/2-1 (mid start bit):
  - rxs=1 means a glitch: return to IDLE, no outputs.
  - rxs=0: clear the counter, go to DATA.
- DATA: sample rxs every OVERSAMPLE ticks (mid-bit). Shift LSB-first into the shift register. After DATA_BITS samples, go to PARITY if PARITY!=0, else STOP.
- PARITY: sample one bit. Error if XOR(data bits, parity bit) != 1 for odd, or != 0 for even.
- STOP: sample after OVERSAMPLE ticks. Then, on the next clk:
  - load rx_data, set rx_valid=1;
  - frame_err = (stop sample==0);
  - parity_err as computed (0 when PARITY=0).
  - If stop=1, go to IDLE. If stop=0, go to BREAK.
- BREAK: wait until a tick with rxs=1, then go to IDLE. No new start is detected while in BREAK.
- Latency: rx_valid rises exactly one clk after the clk carrying the stop-bit sample tick.
- Handshake:
  - rx_valid && rx_ready clears rx_valid the next clk. rx_data and the error flags hold their value until the next load.
  - rx_ready while rx_valid=0 has no effect.
- Overrun: a load while rx_valid=1 and not being consumed that cycle overwrites rx_data and the flags, keeps rx_valid=1, and pulses overrun for 1 clk.
- Simultaneous consume and load in the same clk: the load wins, rx_valid stays 1, no overrun.
- rx_clk is ignored outside tick cycles; counters never advance without a tick.

Test Plan:
- Nominal: OVERSAMPLE=16, PARITY=0; send 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) with rx_ready=0 -> rx_valid=1 with rx_data=0xA5, frame_err=0, parity_err=0. Then pulse rx_ready -> rx_valid=0 next clk.
- Glitch: rxd low for 5 ticks then high -> stays IDLE, rx_valid never asserts. A following 0x3C frame is received correctly.
- Framing/break: send 0x55 with stop bit=0, rxd held low 40 ticks -> rx_data=0x55, frame_err=1. Next frame 0x0F is accepted only after rxd returns high, and yields frame_err=0.
- Parity: PARITY=2, send 0x07 with parity bit 0 -> parity_err=1. Resend with parity bit 1 -> parity_err=0.
- Overrun: two back-to-back frames 0x11, 0x22 with rx_ready=0 -> overrun pulses 1 clk, rx_data=0x22, rx_valid=1.
- Reset mid-frame: assert rst during data bit 3 of 0xFF -> all outputs 0 next clk. A subsequent full 0x81 frame is received correctly.
